// File: rtl/poly_eval_pkg.sv
// Shared constants for the Horner polynomial evaluator: FSM state encoding.
package poly_eval_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_LOAD      = 2'd0;
  localparam logic [STATE_W-1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] S_COMPUTE   = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE      = 2'd3;

endpackage

// File: rtl/poly_eval_horner_mac.sv
// One Horner step: acc*x + c at full precision, truncated result plus an
// overflow flag for any bit at or above WIDTH.
module poly_mac #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH:0]   w_full;

  // Operands are widened before the multiply so no product bits are lost.
  assign w_prod = {{WIDTH{1'b0}}, i_acc} * {{WIDTH{1'b0}}, i_x};
  assign w_full = {1'b0, w_prod} + {{(WIDTH+1){1'b0}}, i_c};

  assign o_sum = w_full[WIDTH-1:0];
  assign o_ovf = |w_full[2*WIDTH:WIDTH];

endmodule

// File: rtl/poly_eval_horner.sv
// Serial-load polynomial evaluator: coefficients (highest power first) then x
// are captured under go press/release, then one Horner MAC per clock.
module poly_eval_horner
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2,
  parameter int IDX_W  = $clog2(DEGREE + 2)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_go,
  input  logic             i_keep_coef,
  input  logic [WIDTH-1:0] i_data_in,
  output logic [IDX_W-1:0] o_load_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_overflow
);

  if (DEGREE < 1) begin : g_bad_degree
    $error("poly_eval_horner: DEGREE must be at least 1");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEGREE + 1);
  localparam logic [IDX_W-1:0] DEG_IDX  = IDX_W'(DEGREE);
  localparam logic [IDX_W-1:0] STEP0    = IDX_W'(DEGREE - 1);

  // Item file in load order: [0] = c[DEGREE] ... [DEGREE] = c[0], [DEGREE+1] = x.
  logic [WIDTH-1:0]   r_item [0:DEGREE+1];
  logic [STATE_W-1:0] r_state;
  logic [IDX_W-1:0]   r_load_idx;
  logic [IDX_W-1:0]   r_step;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_overflow;
  logic               r_ovf_run;

  logic [IDX_W-1:0]   w_rd_idx;
  logic [WIDTH-1:0]   w_sum;
  logic               w_ovf;

  // c[step] lives at load position DEGREE-step.
  assign w_rd_idx = DEG_IDX - r_step;

  poly_mac #(.WIDTH(WIDTH)) u_mac (
    .i_acc (r_acc),
    .i_x   (r_item[DEGREE+1]),
    .i_c   (r_item[w_rd_idx]),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_LOAD;
      r_load_idx <= '0;
      r_step     <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_ovf_run  <= 1'b0;
      // NOTE: the item file is a handful of flops that must read as zero after
      // reset, so it is cleared explicitly rather than left to power-up.
      for (int i = 0; i <= DEGREE + 1; i++) r_item[i] <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_item[r_load_idx] <= i_data_in;
          if (i_go) r_state <= S_LOAD_WAIT;
        end
        S_LOAD_WAIT: begin
          if (!i_go) begin
            if (r_load_idx == LAST_IDX) begin
              r_state   <= S_COMPUTE;
              r_acc     <= r_item[0];
              r_step    <= STEP0;
              r_ovf_run <= 1'b0;
            end else begin
              r_load_idx <= r_load_idx + 1'b1;
              r_state    <= S_LOAD;
            end
          end
        end
        S_COMPUTE: begin
          r_acc <= w_sum;
          if (w_ovf) r_ovf_run <= 1'b1;
          if (r_step == '0) r_state <= S_DONE;
          else              r_step  <= r_step - 1'b1;
        end
        S_DONE: begin
          r_result   <= r_acc;
          r_overflow <= r_ovf_run;
          r_load_idx <= i_keep_coef ? LAST_IDX : '0;
          r_state    <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign o_load_idx = r_load_idx;
  assign o_busy     = (r_state == S_COMPUTE) || (r_state == S_DONE);
  assign o_done     = (r_state == S_DONE);
  assign o_result   = r_result;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_poly_eval_horner.sv
// Bench for poly_eval_horner: a WIDTH=8/DEGREE=2 and a WIDTH=16/DEGREE=4
// instance, vector table, directed corner sequences and random passes.
module tb_poly_eval_horner;

  logic clk = 1'b0;
  logic resetn;

  logic        a_go, a_keep;
  logic [7:0]  a_data;
  logic [1:0]  a_idx;
  logic        a_busy, a_done, a_ovf;
  logic [7:0]  a_result;

  logic        b_go, b_keep;
  logic [15:0] b_data;
  logic [2:0]  b_idx;
  logic        b_busy, b_done, b_ovf;
  logic [15:0] b_result;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  poly_eval_horner #(.WIDTH(8), .DEGREE(2)) u_dut_a (
    .clk(clk), .resetn(resetn), .i_go(a_go), .i_keep_coef(a_keep),
    .i_data_in(a_data), .o_load_idx(a_idx), .o_busy(a_busy),
    .o_done(a_done), .o_result(a_result), .o_overflow(a_ovf)
  );

  poly_eval_horner #(.WIDTH(16), .DEGREE(4)) u_dut_b (
    .clk(clk), .resetn(resetn), .i_go(b_go), .i_keep_coef(b_keep),
    .i_data_in(b_data), .o_load_idx(b_idx), .o_busy(b_busy),
    .o_done(b_done), .o_result(b_result), .o_overflow(b_ovf)
  );

  typedef struct {
    string name;
    int    c2, c1, c0, x;
    int    exp_res;
    bit    exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rd_result(input bit sel);
    return sel ? 64'(b_result) : 64'(a_result);
  endfunction
  function automatic logic [63:0] rd_idx(input bit sel);
    return sel ? 64'(b_idx) : 64'(a_idx);
  endfunction
  function automatic logic rd_ovf(input bit sel);  return sel ? b_ovf  : a_ovf;  endfunction
  function automatic logic rd_busy(input bit sel); return sel ? b_busy : a_busy; endfunction
  function automatic logic rd_done(input bit sel); return sel ? b_done : a_done; endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One press/release of go with data_in held at v.
  task automatic press(input bit sel, input int v);
    if (sel) begin b_data = 16'(v); b_go = 1'b1; end
    else     begin a_data = 8'(v);  a_go = 1'b1; end
    tick();
    if (sel) b_go = 1'b0; else a_go = 1'b0;
    tick();
  endtask

  // Presses n items; returns edges from the final release to done, the number
  // of busy cycles seen, and leaves time on the cycle after done.
  task automatic run_eval(input bit sel, input int n, input int items[6], input bit keep,
                          output int lat, output int bcnt, output bit to);
    if (sel) b_keep = keep; else a_keep = keep;
    for (int i = 0; i < n; i++) press(sel, items[i]);
    lat = 1; bcnt = 0; to = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rd_busy(sel)) bcnt++;
      if (rd_done(sel)) begin to = 1'b0; break; end
      tick();
      lat++;
    end
    tick();
    if (sel) b_keep = 1'b0; else a_keep = 1'b0;
  endtask

  // Reference: result from the power-series definition mod 2^w; overflow from
  // the Horner intermediates exceeding w bits. items are in load order.
  function automatic void model(input int w, input int deg, input int items[6],
                                output longint res, output bit ovf);
    longint mask, x, p, a, t;
    mask = (longint'(1) << w) - 1;
    x = items[deg+1];
    res = 0; p = 1;
    for (int k = 0; k <= deg; k++) begin
      res = (res + longint'(items[deg-k]) * p) & mask;
      p = (p * x) & mask;
    end
    ovf = 1'b0;
    a = items[0];
    for (int i = 1; i <= deg; i++) begin
      t = a * x + items[i];
      if (t > mask) ovf = 1'b1;
      a = t & mask;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[6];
    int     items[6];
    int     lat, bcnt, dones;
    bit     to, m_ovf;
    longint m_res;

    vecs[0] = '{"basic",   3,   5,   7,   2,  29, 1'b0};
    vecs[1] = '{"ovf",     16,  0,   0,  16,   0, 1'b1};
    vecs[2] = '{"ones",    1,   1,   1,   2,   7, 1'b0};
    vecs[3] = '{"x0",      200, 100, 50,  0,  50, 1'b0};
    vecs[4] = '{"x1",      200, 100, 50,  1,  94, 1'b1};
    vecs[5] = '{"allmax",  255, 255, 255, 255, 255, 1'b1};

    resetn = 1'b0;
    a_go = 0; a_keep = 0; a_data = '0;
    b_go = 0; b_keep = 0; b_data = '0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    check("reset_idx",    rd_idx(0),    0);
    check("reset_busy",   rd_busy(0),   0);
    check("reset_done",   rd_done(0),   0);
    check("reset_result", rd_result(0), 0);
    check("reset_ovf",    rd_ovf(0),    0);

    foreach (vecs[i]) begin
      items = '{vecs[i].c2, vecs[i].c1, vecs[i].c0, vecs[i].x, 0, 0};
      run_eval(0, 4, items, 1'b0, lat, bcnt, to);
      check({vecs[i].name, "_timeout"}, to, 0);
      check({vecs[i].name, "_latency"}, lat, 3);
      check({vecs[i].name, "_busy_cycles"}, bcnt, 3);
      check({vecs[i].name, "_result"}, rd_result(0), vecs[i].exp_res);
      check({vecs[i].name, "_ovf"}, rd_ovf(0), vecs[i].exp_ovf);
      check({vecs[i].name, "_idx"}, rd_idx(0), 0);
      check({vecs[i].name, "_busy_after"}, rd_busy(0), 0);
    end

    // Keep-coefficients: basic load, then x-only re-evaluations.
    items = '{3, 5, 7, 2, 0, 0};
    run_eval(0, 4, items, 1'b1, lat, bcnt, to);
    check("keep_first_result", rd_result(0), 29);
    check("keep_idx", rd_idx(0), 3);
    items = '{3, 0, 0, 0, 0, 0};
    run_eval(0, 1, items, 1'b0, lat, bcnt, to);
    check("keep_x3_timeout", to, 0);
    check("keep_x3_latency", lat, 3);
    check("keep_x3_result", rd_result(0), 49);
    check("keep_x3_ovf", rd_ovf(0), 0);
    check("keep_x3_idx", rd_idx(0), 0);

    // Long go: captured value is data_in on the cycle go rose; one advance only.
    a_data = 8'd9; a_go = 1'b1;
    tick();
    a_data = 8'd200;
    repeat (49) tick();
    check("longgo_idx_held", rd_idx(0), 0);
    check("longgo_busy", rd_busy(0), 0);
    a_go = 1'b0;
    tick();
    check("longgo_idx_adv", rd_idx(0), 1);
    items = '{5, 7, 2, 0, 0, 0};
    run_eval(0, 3, items, 1'b0, lat, bcnt, to);
    check("longgo_result", rd_result(0), 53);

    // Go held across done: one load cycle then straight to the wait state.
    items = '{1, 2, 3, 4, 0, 0};
    for (int i = 0; i < 4; i++) press(0, items[i]);
    a_go = 1'b1; a_data = 8'd11;
    repeat (4) tick();
    check("golong_done_idx", rd_idx(0), 0);
    a_go = 1'b0;
    tick();
    check("golong_next_idx", rd_idx(0), 1);
    check("golong_result", rd_result(0), 1*16 + 2*4 + 3);
    items = '{0, 0, 2, 0, 0, 0};
    run_eval(0, 3, items, 1'b0, lat, bcnt, to);
    check("golong_captured_c2", rd_result(0), 44);

    // Reset in the middle of compute.
    items = '{3, 5, 7, 2, 0, 0};
    for (int i = 0; i < 4; i++) press(0, items[i]);
    check("midrst_busy_before", rd_busy(0), 1);
    resetn = 1'b0;
    tick();
    check("midrst_busy", rd_busy(0), 0);
    check("midrst_done", rd_done(0), 0);
    check("midrst_result", rd_result(0), 0);
    check("midrst_ovf", rd_ovf(0), 0);
    check("midrst_idx", rd_idx(0), 0);
    resetn = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rd_done(0)) dones++;
    end
    check("midrst_no_done", dones, 0);

    // Wider/deeper instance.
    items = '{1, 2, 3, 4, 5, 10};
    run_eval(1, 6, items, 1'b0, lat, bcnt, to);
    check("sweep_timeout", to, 0);
    check("sweep_latency", lat, 5);
    check("sweep_busy_cycles", bcnt, 5);
    check("sweep_result", rd_result(1), 12345);
    check("sweep_ovf", rd_ovf(1), 0);
    check("sweep_busy_after", rd_busy(1), 0);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 4; i++) items[i] = int'($urandom_range(255));
      if (r % 4 == 0) items[3] = int'($urandom_range(1));
      model(8, 2, items, m_res, m_ovf);
      run_eval(0, 4, items, 1'b0, lat, bcnt, to);
      check("rand_a_result", rd_result(0), m_res);
      check("rand_a_ovf", rd_ovf(0), m_ovf);
    end

    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 6; i++) items[i] = int'($urandom_range(r < 5 ? 15 : 65535));
      model(16, 4, items, m_res, m_ovf);
      run_eval(1, 6, items, 1'b0, lat, bcnt, to);
      check("rand_b_latency", lat, 5);
      check("rand_b_result", rd_result(1), m_res);
      check("rand_b_ovf", rd_ovf(1), m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_eval_horner.md
Name: poly_eval_horner

Overview:
Parametrised polynomial evaluator. It computes P(x) = c[DEGREE]·x^DEGREE + … + c[1]·x + c[0] using Horner's method, with one multiply-accumulate per clock. Coefficients and x are loaded serially from switch-style data_in under go press/release control. It sits between the board I/O wrapper (SW/KEY in; LEDR/HEX out through hex_decoder) and replaces the fixed-function quadratic control/datapath pair. It adds arbitrary degree and width, overflow detection, done/busy status, and a keep-coefficients mode that re-evaluates for a new x only.

Parameters:
- WIDTH, 8: width of data_in, coefficients, x, accumulator and result.
- DEGREE, 2: polynomial degree. Must be ≥1; elaboration fails otherwise.
- IDX_W, $clog2(DEGREE+2): width of load_idx (derived; do not override).

Ports:
- clk, input, 1: clock.
- resetn, input, 1: reset, synchronous, active-low.
- go, input, 1: load-advance strobe, active-high, level (already inverted KEY).
- keep_coef, input, 1: sampled in S_DONE. 1 = next pass loads x only.
- data_in, input, WIDTH: coefficient / x value.
- load_idx, output, IDX_W: item currently loading. 0 = c[DEGREE] … DEGREE = c[0], DEGREE+1 = x.
- busy, output, 1: high in S_COMPUTE and S_DONE.
- done, output, 1: one-cycle pulse when result updates.
- result, output, WIDTH: last evaluated P(x), truncated mod 2^WIDTH.
- overflow, output, 1: set if any step of the last evaluation exceeded WIDTH bits.

Behaviour:
- Reset (resetn=0 at posedge clk, from any state including mid-compute):
  - state=S_LOAD, load_idx=0.
  - All coefficient registers, x, acc, result = 0.
  - overflow=0, done=0, busy=0.
- States: S_LOAD, S_LOAD_WAIT, S_COMPUTE, S_DONE.
- S_LOAD:
  - Register selected by load_idx captures data_in every cycle.
  - go=1 → S_LOAD_WAIT; otherwise stay.
- S_LOAD_WAIT:
  - No register loads.
  - go=1 → stay (holding go any length has no further effect).
  - go=0 and load_idx<DEGREE+1 → load_idx+1, S_LOAD.
  - go=0 and load_idx==DEGREE+1 → S_COMPUTE; on this transition acc←c[DEGREE], step←DEGREE-1, overflow←0.
- S_COMPUTE:
  - Each cycle: acc ← (acc·x + c[step]) mod 2^WIDTH.
  - Full-precision sum is 2·WIDTH+1 bits. If any bit ≥WIDTH is nonzero, overflow←1 (sticky within the evaluation).
  - step==0 → S_DONE; else step−1.
  - Occupies exactly DEGREE cycles.
- S_DONE (1 cycle):
  - result←acc, done=1.
  - Next state is S_LOAD with load_idx ← keep_coef ? DEGREE+1 : 0.
- Latency: go falling edge on the x load → done pulse is DEGREE+1 cycles later. result is valid and overflow is final on the cycle after done.
- result and overflow hold their values until the next S_DONE or reset.
- go is ignored in S_COMPUTE and S_DONE. A go held high across S_DONE into S_LOAD moves straight to S_LOAD_WAIT after one load cycle (same as a fresh press).
- All arithmetic is unsigned. x=0 gives result=c[0]. x=1 gives the sum of coefficients mod 2^WIDTH.

Decomposition:
- Package poly_eval_pkg: state encoding localparams (S_LOAD=0, S_LOAD_WAIT=1, S_COMPUTE=2, S_DONE=3), state width 2.
- Sub-module poly_mac (combinational, parametrised WIDTH):
  - Inputs: acc, x, c.
  - Outputs: truncated WIDTH-bit sum and ovf bit.
- FSM, load_idx/step counters and register file stay in poly_eval_horner.

Test Plan:
- Basic: WIDTH=8, DEGREE=2; load c2=3, c1=5, c0=7, x=2 via press/release → done pulse 3 cycles after last go release; result=0x1D (29); overflow=0; load_idx returns to 0.
- Overflow: c2=16, c1=0, c0=0, x=16 → result=0x00, overflow=1. Then a new full load with c2=1, c1=1, c0=1, x=2 → result=7, overflow=0.
- Keep coefficients: after the basic case, hold keep_coef=1 at done → load_idx=3. Load x=3 only → result=49 (0x31). Coefficients unchanged.
- Long go / reset mid-op:
  - Hold go 50 cycles on c2 → only one advance; value captured is data_in on the cycle go rose.
  - Assert resetn=0 during S_COMPUTE → next cycle state S_LOAD, result=0, busy=0, no done pulse.
- Parameter sweep: WIDTH=16, DEGREE=4; c=1,2,3,4,5 (c4 first), x=10 → result=12345 (0x3039); done after 5 cycles; busy high for exactly 5 cycles.
- Degenerate x: DEGREE=2, c=200,100,50, x=0 → result=50, overflow=0. Same coefficients with x=1 → result=350 mod 256=94, overflow=1.
